// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared types and sizing helpers for the pipeline trace buffer
package cpu_trace_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} trace_state_e;
  localparam int CH_F = 0;
  localparam int CH_D = 1;
  localparam int CH_E = 2;
  localparam int CH_M = 3;
  localparam int CH_W = 4;
  function automatic int REC_W(int num_ch, int data_w);
    return num_ch * (data_w + 1);
  endfunction
endpackage

// File: rtl/trace_ram.sv
// trace_ram: simple dual-port RAM, one write port and one registered read port
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 165
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: per-cycle pipeline stage capture into a circular buffer,
// frozen by a match or external trigger and then read back oldest-first.
module pipe_trace_buffer import cpu_trace_pkg::*; #(
  parameter int NUM_CH = CH_W + 1,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH),
  parameter int SW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int RW     = REC_W(NUM_CH, DATA_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_arm,
  input  logic                     i_abort,
  input  logic                     i_cap_en,
  input  logic                     i_trig_ext,
  input  logic [SW-1:0]            i_trig_sel,
  input  logic [DATA_W-1:0]        i_trig_val,
  input  logic [DATA_W-1:0]        i_trig_mask,
  input  logic [AW-1:0]            i_post_count,
  input  logic [NUM_CH-1:0]        i_ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] i_ch_data,
  input  logic                     i_rd_req,
  input  logic [AW-1:0]            i_rd_addr,
  output logic [RW-1:0]            o_rd_data,
  output logic                     o_rd_valid,
  output logic                     o_rd_err,
  output logic [1:0]               o_state,
  output logic [AW:0]              o_fill,
  output logic [AW-1:0]            o_trig_idx
);
  trace_state_e r_state, w_next;
  logic [AW-1:0] r_wr_ptr, r_post_cnt, r_trig_slot, w_base, w_rd_phys;
  logic [AW:0]   r_fill;
  logic          r_rd_valid, r_rd_err;
  logic          w_match, w_trig, w_we, w_re, w_arm_ok;
  logic [RW-1:0] w_rec, w_ram_q;

  always_comb begin
    w_rec   = '0;
    w_match = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_rec[k*(DATA_W+1) +: DATA_W+1] = {i_ch_valid[k], i_ch_data[k*DATA_W +: DATA_W]};
      if (i_trig_sel == SW'(k) && i_ch_valid[k] &&
          ((i_ch_data[k*DATA_W +: DATA_W] ^ i_trig_val) & i_trig_mask) == '0)
        w_match = 1'b1;
    end
  end

  assign w_we      = (r_state == ARMED || r_state == POST) && i_cap_en && !i_abort;
  assign w_trig    = r_state == ARMED && i_cap_en && (i_trig_ext || w_match);
  assign w_arm_ok  = i_arm && !i_abort && (r_state == IDLE || r_state == DONE);
  assign w_re      = i_rd_req && r_state == DONE;
  // oldest retained sample sits fill entries behind the write pointer
  assign w_base    = r_wr_ptr - r_fill[AW-1:0];
  assign w_rd_phys = w_base + i_rd_addr;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (i_arm) w_next = ARMED;
      ARMED: if (w_trig) w_next = (r_post_cnt == '0) ? DONE : POST;
      POST:  if (i_cap_en && r_post_cnt == AW'(1)) w_next = DONE;
      DONE:  if (i_arm) w_next = ARMED;
      default: w_next = IDLE;
    endcase
    if (i_abort) w_next = IDLE;
  end

  always_comb o_state = r_state;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_post_cnt  <= '0;
      r_trig_slot <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_err    <= 1'b0;
    end else begin
      if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_abort || w_arm_ok) r_fill <= '0;
      else if (w_we && r_fill != (AW+1)'(DEPTH)) r_fill <= r_fill + 1'b1;
      if (w_arm_ok) r_post_cnt <= i_post_count;
      else if (r_state == POST && i_cap_en) r_post_cnt <= r_post_cnt - 1'b1;
      if (w_trig) r_trig_slot <= r_wr_ptr;
      r_rd_valid <= w_re;
      r_rd_err   <= w_re && {1'b0, i_rd_addr} >= r_fill;
    end

  trace_ram #(.DEPTH(DEPTH), .AW(AW), .W(RW)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_rec),
    .i_re    (w_re),
    .i_raddr (w_rd_phys),
    .o_rdata (w_ram_q)
  );

  assign o_rd_data  = (r_rd_valid && !r_rd_err) ? w_ram_q : '0;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_err   = r_rd_err;
  assign o_fill     = r_fill;
  assign o_trig_idx = r_trig_slot - w_base;
endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb_pipe_trace_buffer: scoreboard bench with a sample-list reference model
module tb_pipe_trace_buffer;
  import cpu_trace_pkg::*;
  localparam int NUM_CH = CH_W - CH_F + 1;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int AW     = 6;
  localparam int SW     = 3;
  localparam int RW     = REC_W(NUM_CH, DATA_W);

  logic clk, rst, arm, abort, cap_en, trig_ext, rd_req;
  logic [SW-1:0] trig_sel;
  logic [DATA_W-1:0] trig_val, trig_mask;
  logic [AW-1:0] post_count, rd_addr;
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [RW-1:0] o_rd_data;
  logic o_rd_valid, o_rd_err;
  logic [1:0] o_state;
  logic [AW:0] o_fill;
  logic [AW-1:0] o_trig_idx;

  pipe_trace_buffer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_arm(arm), .i_abort(abort), .i_cap_en(cap_en),
    .i_trig_ext(trig_ext), .i_trig_sel(trig_sel), .i_trig_val(trig_val),
    .i_trig_mask(trig_mask), .i_post_count(post_count), .i_ch_valid(ch_valid),
    .i_ch_data(ch_data), .i_rd_req(rd_req), .i_rd_addr(rd_addr),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_rd_err(o_rd_err),
    .o_state(o_state), .o_fill(o_fill), .o_trig_idx(o_trig_idx)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc++;

  // reference: ordered list of retained samples since arm, plus trigger position
  int m_state = 0, m_n = 0, m_trig = 0, m_left = 0;
  logic [RW-1:0] m_q[$];
  logic [RW-1:0] exp_dat[$];
  bit exp_err[$];
  int exp_cyc[$];

  task automatic chk(string nm, logic [RW-1:0] act, logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] rec();
    logic [RW-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_CH; k++)
      r[k*(DATA_W+1) +: DATA_W+1] = {ch_valid[k], ch_data[k*DATA_W +: DATA_W]};
    return r;
  endfunction

  function automatic bit mmatch();
    int s;
    s = int'(trig_sel);
    if (s >= NUM_CH) return 0;
    return ch_valid[s] && (((ch_data[s*DATA_W +: DATA_W] ^ trig_val) & trig_mask) == 0);
  endfunction

  task automatic model_edge();
    if (abort) begin
      m_state = 0; m_q.delete(); m_n = 0;
    end else if ((m_state == 0 || m_state == 3) && arm) begin
      m_state = 1; m_q.delete(); m_n = 0; m_left = int'(post_count);
    end else if ((m_state == 1 || m_state == 2) && cap_en) begin
      m_q.push_back(rec());
      m_n++;
      if (m_q.size() > DEPTH) void'(m_q.pop_front());
      if (m_state == 1) begin
        if (trig_ext || mmatch()) begin
          m_trig = m_n - 1;
          m_state = (m_left == 0) ? 3 : 2;
        end
      end else begin
        m_left--;
        if (m_left == 0) m_state = 3;
      end
    end
  endtask

  task automatic tick();
    if (rd_req && m_state == 3) begin
      int a;
      a = int'(rd_addr);
      exp_cyc.push_back(cyc + 1);
      exp_err.push_back(a >= m_q.size());
      exp_dat.push_back(a < m_q.size() ? m_q[a] : '0);
    end
    model_edge();
    @(posedge clk);
    #1;
    chk("state", RW'(o_state), RW'(m_state));
    chk("fill", RW'(o_fill), RW'(m_q.size()));
    if (m_state == 3) chk("trig_idx", RW'(o_trig_idx), RW'(m_trig - (m_n - m_q.size())));
  endtask

  always @(negedge clk) begin
    if (exp_cyc.size() > 0 && exp_cyc[0] < cyc) begin
      chk("rd_valid_missing", RW'(1'b0), RW'(1'b1));
      void'(exp_cyc.pop_front()); void'(exp_err.pop_front()); void'(exp_dat.pop_front());
    end
    if (o_rd_valid) begin
      if (exp_cyc.size() == 0) chk("rd_valid_unexpected", RW'(1'b1), RW'(1'b0));
      else begin
        chk("rd_latency", RW'(cyc), RW'(exp_cyc.pop_front()));
        chk("rd_err", RW'(o_rd_err), RW'(exp_err.pop_front()));
        chk("rd_data", o_rd_data, exp_dat.pop_front());
      end
    end
  end

  task automatic rnd_ch();
    for (int k = 0; k < NUM_CH; k++) ch_data[k*DATA_W +: DATA_W] = $urandom;
    ch_valid = NUM_CH'($urandom);
  endtask

  initial begin
    rst = 1; arm = 0; abort = 0; cap_en = 0; trig_ext = 0; rd_req = 0;
    trig_sel = 0; trig_val = 0; trig_mask = 0; post_count = 0; rd_addr = 0;
    ch_valid = 0; ch_data = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", RW'(o_state), RW'(0));
    chk("rst_fill", RW'(o_fill), RW'(0));
    chk("rst_trig_idx", RW'(o_trig_idx), RW'(0));
    chk("rst_rd_valid", RW'(o_rd_valid), RW'(0));
    chk("rst_rd_err", RW'(o_rd_err), RW'(0));
    chk("rst_rd_data", o_rd_data, RW'(0));
    rst = 0;
    // T1: match on execute-stage PC
    trig_sel = SW'(CH_E); trig_val = 32'h10; trig_mask = '1; post_count = 3;
    arm = 1; tick(); arm = 0;
    cap_en = 1;
    for (int i = 0; i < 9; i++) begin
      rnd_ch();
      ch_valid[CH_E] = 1'b1;
      ch_data[CH_E*DATA_W +: DATA_W] = (i == 5) ? 32'h10 : 32'h100 + i;
      tick();
    end
    cap_en = 0;
    chk("t1_state", RW'(o_state), RW'(3));
    chk("t1_fill", RW'(o_fill), RW'(9));
    chk("t1_trig_idx", RW'(o_trig_idx), RW'(5));
    rd_req = 1;
    for (int a = 0; a < 10; a++) begin rd_addr = AW'(a); tick(); end
    rd_addr = 20; tick();
    rd_req = 0; tick();
    chk("t6_rd_data_zero", o_rd_data, RW'(0));
    // T2: wrap-around with external trigger; out-of-range select never matches
    trig_sel = 3'd7; trig_mask = '0; post_count = 10;
    arm = 1; tick(); arm = 0;
    cap_en = 1;
    for (int i = 0; i < 100; i++) begin rnd_ch(); tick(); end
    chk("t2_no_match", RW'(o_state), RW'(1));
    trig_ext = 1; rnd_ch(); tick(); trig_ext = 0;
    for (int i = 0; i < 10; i++) begin rnd_ch(); tick(); end
    cap_en = 0;
    chk("t2_state", RW'(o_state), RW'(3));
    chk("t2_fill", RW'(o_fill), RW'(64));
    chk("t2_trig_idx", RW'(o_trig_idx), RW'(53));
    rd_req = 1;
    rd_addr = 0; tick();
    rd_addr = 53; tick();
    rd_addr = 63; tick();
    for (int i = 0; i < 5; i++) begin rd_addr = AW'($urandom); tick(); end
    rd_req = 0; tick();
    // T3: stalls during POST are not counted
    trig_sel = SW'(CH_M); trig_mask = '0; post_count = 2;
    arm = 1; tick(); arm = 0;
    cap_en = 1; rnd_ch(); ch_valid = 5'b01000; tick();
    ch_valid = 0; tick();
    cap_en = 0;
    for (int i = 0; i < 4; i++) begin rnd_ch(); tick(); end
    chk("t3_stalled", RW'(o_state), RW'(2));
    cap_en = 1; rnd_ch(); tick(); cap_en = 0;
    chk("t3_state", RW'(o_state), RW'(3));
    chk("t3_fill", RW'(o_fill), RW'(3));
    // T4: masked compare on decode channel
    trig_sel = SW'(CH_D); trig_val = 32'h1234_5600; trig_mask = 32'hFFFF_FF00; post_count = 0;
    arm = 1; tick(); arm = 0;
    cap_en = 1; rnd_ch(); ch_data[CH_D*DATA_W +: DATA_W] = 32'h1234_56AB;
    ch_valid[CH_D] = 1'b0; tick();
    chk("t4_invalid_no_trig", RW'(o_state), RW'(1));
    ch_valid[CH_D] = 1'b1; tick(); cap_en = 0;
    chk("t4_trig", RW'(o_state), RW'(3));
    // T5: abort beats arm, then async reset mid-POST
    trig_sel = SW'(CH_F); trig_mask = '1; trig_val = '1; post_count = 20;
    arm = 1; tick(); arm = 0;
    cap_en = 1; trig_ext = 1; rnd_ch(); tick(); trig_ext = 0;
    for (int i = 0; i < 3; i++) begin rnd_ch(); tick(); end
    abort = 1; arm = 1; tick(); abort = 0; arm = 0;
    chk("t5_abort_state", RW'(o_state), RW'(0));
    chk("t5_abort_fill", RW'(o_fill), RW'(0));
    arm = 1; tick(); arm = 0;
    trig_ext = 1; rnd_ch(); tick(); trig_ext = 0;
    rnd_ch(); tick(); rnd_ch(); tick();
    #2 rst = 1;
    #1;
    chk("t5_rst_state", RW'(o_state), RW'(0));
    chk("t5_rst_rd_valid", RW'(o_rd_valid), RW'(0));
    m_state = 0; m_q.delete(); m_n = 0;
    @(posedge clk); #1 rst = 0;
    cap_en = 0;
    tick();
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      arm = ($urandom % 12) == 0;
      abort = ($urandom % 64) == 0;
      cap_en = ($urandom % 4) != 0;
      trig_ext = ($urandom % 25) == 0;
      trig_sel = SW'($urandom);
      trig_mask = 32'($urandom) & 32'h7;
      trig_val = 32'($urandom);
      post_count = (($urandom % 8) == 0) ? AW'(63) : AW'($urandom % 6);
      rd_req = $urandom % 2;
      rd_addr = AW'($urandom);
      rnd_ch();
      tick();
    end
    arm = 0; abort = 0; cap_en = 0; trig_ext = 0; rd_req = 0;
    tick(); tick();
    chk("sb_drained", RW'(exp_cyc.size()), RW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
